fp16_norm_seq: RTL and testbench

//  Multi-cycle normalizer placed directly downstream of the FP16 adder datapath.

---
 rtl/fp16_norm_seq.sv | 139 +++++++++++++
 tb/tb_fp16_norm_seq.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fp16_norm_seq.sv
// Post-adder normalizer: turns a raw sign/exponent/12-bit sum into a binary16 word,
// shifting left one bit per cycle after cancellation and flagging overflow/underflow/zero.
module fp16_norm_seq #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [EXP_W-1:0]       in_exp,
  input  logic [MAN_W+1:0]       in_mant,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_result,
  output logic [2:0]             out_flags,
  output logic                   busy
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  localparam logic [EXP_W-1:0] EXP_MAX   = '1;
  localparam logic [EXP_W:0]   EXP_MAX_W = {1'b0, EXP_MAX};
  localparam logic [EXP_W:0]   EXP_ONE_W = (EXP_W+1)'(1);
  localparam logic [2:0]       F_NONE    = 3'b000;
  localparam logic [2:0]       F_OVF     = 3'b100;
  localparam logic [2:0]       F_UNF     = 3'b010;
  localparam logic [2:0]       F_ZERO    = 3'b001;

  state_t                 r_state;
  logic                   r_sign;
  logic [EXP_W:0]         r_exp;
  logic [MAN_W:0]         r_mant;
  logic                   r_out_valid;
  logic [EXP_W+MAN_W:0]   r_result;
  logic [2:0]             r_flags;

  logic                   w_accept;
  logic [EXP_W:0]         w_exp_inc;
  logic [EXP_W:0]         w_exp_dec;
  logic [MAN_W:0]         w_mant_sh;

  function automatic logic [EXP_W+MAN_W:0] pack(input logic s, input logic [EXP_W-1:0] e,
                                                input logic [MAN_W-1:0] f);
    return {s, e, f};
  endfunction

  assign w_accept  = in_valid && (r_state == S_IDLE);
  assign w_exp_inc = {1'b0, in_exp} + EXP_ONE_W;
  assign w_exp_dec = r_exp - EXP_ONE_W;
  assign w_mant_sh = r_mant << 1;

  assign in_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign out_valid  = r_out_valid;
  assign out_result = r_result;
  assign out_flags  = r_flags;

  // Working sign/exponent/mantissa carry no reset; they are only read in SHIFT after a load.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_sign <= in_sign;
      r_exp  <= {1'b0, in_exp};
      r_mant <= in_mant[MAN_W:0];
    end else if (r_state == S_SHIFT) begin
      r_exp  <= w_exp_dec;
      r_mant <= w_mant_sh;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            if (in_mant == '0) begin
              r_result <= '0;
              r_flags  <= F_ZERO;
            end else if (in_exp == EXP_MAX) begin
              r_result <= pack(in_sign, EXP_MAX, '0);
              r_flags  <= F_OVF;
            end else if (in_exp == '0) begin
              r_result <= pack(in_sign, '0, '0);
              r_flags  <= F_UNF;
            end else if (in_mant[MAN_W+1]) begin
              // Carry-out: one right shift, dropped LSB is truncated.
              if (w_exp_inc >= EXP_MAX_W) begin
                r_result <= pack(in_sign, EXP_MAX, '0);
                r_flags  <= F_OVF;
              end else begin
                r_result <= pack(in_sign, w_exp_inc[EXP_W-1:0], in_mant[MAN_W:1]);
                r_flags  <= F_NONE;
              end
            end else if (in_mant[MAN_W]) begin
              r_result <= pack(in_sign, in_exp, in_mant[MAN_W-1:0]);
              r_flags  <= F_NONE;
            end else begin
              r_state     <= S_SHIFT;
              r_out_valid <= 1'b0;
            end
          end
        end
        S_SHIFT: begin
          // Underflow is tested before shifting so exponent never reaches zero as a normal.
          if (r_exp <= EXP_ONE_W) begin
            r_result    <= pack(r_sign, '0, '0);
            r_flags     <= F_UNF;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_mant_sh[MAN_W]) begin
            r_result    <= pack(r_sign, w_exp_dec[EXP_W-1:0], w_mant_sh[MAN_W-1:0]);
            r_flags     <= F_NONE;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_norm_seq.sv
// Directed bench for fp16_norm_seq: per-scenario tasks with hand-computed binary16 results.
module tb_fp16_norm_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [4:0]  in_exp;
  logic [11:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_flags;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  fp16_norm_seq #(.EXP_W(5), .MAN_W(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accept one operand, then wait (bounded) for out_valid; lat counts edges from accept.
  task automatic do_op(input logic s, input logic [4:0] e, input logic [11:0] m,
                       output logic [15:0] res, output logic [2:0] fl, output int lat);
    @(negedge clk);
    in_sign = s; in_exp = e; in_mant = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    res = out_result;
    fl  = out_flags;
  endtask

  task automatic drain(output logic ov, output logic ir);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    ov = out_valid;
    ir = in_ready;
  endtask

  task automatic test_reset();
    n_vec++;
    if ({out_valid, out_result, out_flags, busy, in_ready} !== {1'b0, 16'h0, 3'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset: got ov=%b res=%h fl=%b busy=%b ir=%b, want 0 0000 000 0 1",
               out_valid, out_result, out_flags, busy, in_ready);
    end
  endtask

  // Each row: sign, exp, mant, expected result, flags, latency
  task automatic test_single_cycle();
    logic [15:0] res; logic [2:0] fl; int lat; logic ov, ir;
    logic [4:0]  t_e [8] = '{5'd15, 5'd15, 5'd10, 5'd30, 5'd31, 5'd0, 5'd31, 5'd15};
    logic [11:0] t_m [8] = '{12'h400, 12'hA00, 12'hFFF, 12'h800, 12'h400, 12'h400, 12'h000, 12'h7FF};
    logic        t_s [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [15:0] t_r [8] = '{16'h3C00, 16'h4100, 16'h2FFF, 16'h7C00, 16'hFC00, 16'h0000, 16'h0000, 16'hBFFF};
    logic [2:0]  t_f [8] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b100, 3'b010, 3'b001, 3'b000};
    for (int i = 0; i < 8; i++) begin
      do_op(t_s[i], t_e[i], t_m[i], res, fl, lat);
      n_vec++;
      if (res !== t_r[i] || fl !== t_f[i] || lat !== 1) begin
        n_bad++;
        $display("FAIL single_cycle[%0d]: got res=%h fl=%b lat=%0d, want %h %b 1",
                 i, res, fl, lat, t_r[i], t_f[i]);
      end
      drain(ov, ir);
      n_vec++;
      if (ov !== 1'b0 || ir !== 1'b1) begin
        n_bad++;
        $display("FAIL single_cycle_drain[%0d]: got ov=%b ir=%b, want 0 1", i, ov, ir);
      end
    end
  endtask

  task automatic test_shift();
    logic [15:0] res; logic [2:0] fl; int lat; logic ov, ir;
    logic [4:0]  t_e [4] = '{5'd2, 5'd20, 5'd3, 5'd2};
    logic [11:0] t_m [4] = '{12'h200, 12'h3FF, 12'h040, 12'h100};
    logic        t_s [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [15:0] t_r [4] = '{16'h0400, 16'hCFFE, 16'h8000, 16'h0000};
    logic [2:0]  t_f [4] = '{3'b000, 3'b000, 3'b010, 3'b010};
    int          t_l [4] = '{2, 2, 4, 3};
    for (int i = 0; i < 4; i++) begin
      do_op(t_s[i], t_e[i], t_m[i], res, fl, lat);
      n_vec++;
      if (res !== t_r[i] || fl !== t_f[i] || lat !== t_l[i]) begin
        n_bad++;
        $display("FAIL shift[%0d]: got res=%h fl=%b lat=%0d, want %h %b %0d",
                 i, res, fl, lat, t_r[i], t_f[i], t_l[i]);
      end
      drain(ov, ir);
    end
  endtask

  task automatic test_cancel();
    int lat; int bad_busy = 0; logic ov, ir;
    @(negedge clk);
    in_sign = 1'b0; in_exp = 5'd15; in_mant = 12'h001; in_valid = 1'b1;
    @(posedge clk); #1;
    // A different operand is held on the input while busy; it must be ignored.
    in_exp = 5'd15; in_mant = 12'h400; in_sign = 1'b1;
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) bad_busy++;
      @(posedge clk); #1;
      lat++;
    end
    n_vec++;
    if (bad_busy != 0) begin
      n_bad++;
      $display("FAIL cancel_busy: got %0d cycles with busy=0 or in_ready=1, want 0", bad_busy);
    end
    n_vec++;
    if (out_result !== 16'h1400 || out_flags !== 3'b000 || lat !== 11) begin
      n_bad++;
      $display("FAIL cancel: got res=%h fl=%b lat=%0d, want 1400 000 11", out_result, out_flags, lat);
    end
    in_valid = 1'b0;
    drain(ov, ir);
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL cancel_ignored: got ov=%b ir=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] res; logic [2:0] fl; int lat; logic ov, ir;
    @(negedge clk);
    in_sign = 1'b0; in_exp = 5'd15; in_mant = 12'h001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, out_result, out_flags, busy, in_ready} !== {1'b0, 16'h0, 3'b0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_mid_op: got ov=%b res=%h fl=%b busy=%b ir=%b, want 0 0000 000 0 1",
               out_valid, out_result, out_flags, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 5'd15, 12'h400, res, fl, lat);
    n_vec++;
    if (res !== 16'h3C00 || fl !== 3'b000 || lat !== 1) begin
      n_bad++;
      $display("FAIL after_reset: got res=%h fl=%b lat=%0d, want 3c00 000 1", res, fl, lat);
    end
    drain(ov, ir);
  endtask

  task automatic test_backpressure();
    logic [15:0] res; logic [2:0] fl; int lat; logic ov, ir; int bad_hold = 0;
    do_op(1'b1, 5'd9, 12'h000, res, fl, lat);
    n_vec++;
    if (res !== 16'h0000 || fl !== 3'b001 || lat !== 1) begin
      n_bad++;
      $display("FAIL zero: got res=%h fl=%b lat=%0d, want 0000 001 1", res, fl, lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || out_result !== 16'h0000 || out_flags !== 3'b001 || in_ready !== 1'b0)
        bad_hold++;
    end
    n_vec++;
    if (bad_hold != 0) begin
      n_bad++;
      $display("FAIL backpressure_hold: got %0d unstable cycles, want 0", bad_hold);
    end
    drain(ov, ir);
    n_vec++;
    if (ov !== 1'b0 || ir !== 1'b1) begin
      n_bad++;
      $display("FAIL backpressure_release: got ov=%b ir=%b, want 0 1", ov, ir);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_single_cycle();
    test_shift();
    test_cancel();
    test_reset_mid_op();
    test_backpressure();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
